// File: rtl/mul_wb_pkg.sv
// MUL/DIV writeback stage: shared parameters, types and helpers.
// Tag FIFO geometry and writeback bundle used by mul_wb and mul_tag_fifo.
package mul_wb_pkg;

  localparam int XLEN       = 32;
  localparam int MULBUF_LEN = 2;
  localparam int MULBUF_OFF = 2;
  localparam int TAG_DEPTH  = 4;
  localparam int PTR_W      = $clog2(TAG_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef logic [4:0] rd_t;

  typedef struct packed {
    logic            vld;
    rd_t             rd;
    logic [XLEN-1:0] data;
  } wb_t;

  function automatic logic [31:0] rd_onehot(input rd_t rd);
    logic [31:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mul_wb_tag_fifo.sv
// In-order rd tag FIFO for issued M-extension ops.
// Exposes head tag, occupancy and a one-hot OR of all queued rds.
module mul_tag_fifo
  import mul_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  rd_t              push_rd,
  output rd_t              head_rd,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      busy
);

  rd_t              mem_q [TAG_DEPTH];
  rd_t              mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign head_rd = mem_q[rptr_q];
  assign count   = count_q;

  // Next pointer/count/storage; flush only rewinds the pointers.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wptr_q] = push_rd;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // OR one-hot rd over the live window [rptr, rptr+count).
  always_comb begin
    logic [PTR_W-1:0] idx;
    busy = '0;
    idx  = '0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      idx = rptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        busy = busy | rd_onehot(mem_q[idx]);
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_wb.sv
// Writeback stage after the MUL/DIV unit: pairs results with rd tags,
// drives a registered regfile port and a pending-rd scoreboard.
module mul_wb
  import mul_wb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_pipeline,
  input  logic                       iss_vld,
  input  logic [4:0]                 iss_rd,
  output logic                       iss_ready,
  input  logic                       mul_in_vld,
  input  logic [MULBUF_LEN*XLEN-1:0] mul_in_data,
  input  logic [MULBUF_OFF-1:0]      mul_this_order,
  output logic                       mul_accept,
  output logic                       wb_vld,
  output logic [4:0]                 wb_rd,
  output logic [XLEN-1:0]            wb_data,
  input  logic                       wb_ready,
  output logic [31:0]                rd_busy,
  output logic                       err_orphan
);

  wb_t              wb_q, wb_d;
  logic             orphan_q, orphan_d;
  logic             push, take;
  rd_t              head_rd;
  logic [CNT_W-1:0] count;
  logic [31:0]      fifo_busy;
  logic             unused_hi;

  assign unused_hi = ^mul_in_data[MULBUF_LEN*XLEN-1:XLEN];

  assign iss_ready  = (count < CNT_W'(TAG_DEPTH));
  assign push       = iss_vld & iss_ready & ~clear_pipeline;
  assign take       = mul_in_vld & (count != '0)
                    & (~wb_q.vld | wb_ready) & ~clear_pipeline;
  assign mul_accept = take;

  mul_tag_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear_pipeline),
    .push    (push),
    .pop     (take),
    .push_rd (iss_rd),
    .head_rd (head_rd),
    .count   (count),
    .busy    (fifo_busy)
  );

  // Output register: load on take with rd!=0, drain on handshake, flush.
  always_comb begin
    wb_d     = wb_q;
    wb_d.vld = wb_q.vld & ~wb_ready;
    if (take && head_rd != '0) begin
      wb_d.vld  = 1'b1;
      wb_d.rd   = head_rd;
      wb_d.data = mul_in_data[XLEN-1:0];
    end
    if (clear_pipeline) begin
      wb_d.vld = 1'b0;
    end
    orphan_d = orphan_q | (mul_in_vld & (count == '0));
  end

  // Writeback port and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      orphan_q <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      orphan_q <= orphan_d;
    end
  end

  assign wb_vld     = wb_q.vld;
  assign wb_rd      = wb_q.rd;
  assign wb_data    = wb_q.data;
  assign err_orphan = orphan_q;
  assign rd_busy    = (fifo_busy
                    | (wb_q.vld ? rd_onehot(wb_q.rd) : 32'h0))
                    & ~32'h1;

  // Unit buffer occupancy must agree with its valid and the tag count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (mul_in_vld == (mul_this_order != '0));
      assert (count == '0 || CNT_W'(mul_this_order) <= count);
    end
  end

endmodule
